// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle coverage collector: mode encodings and
// helpers for sizing the coverage point space and the handshake counter.
package toggle_cover_pkg;

  localparam int TOGGLE_LEVEL = 0;
  localparam int TOGGLE_EDGE  = 1;

  // Number of coverage points produced by a monitored bus of the given width.
  function automatic int cover_points(input int width, input int mode);
    return (mode == TOGGLE_EDGE) ? 2 * width : width;
  endfunction

  // Bits needed to count from 0 up to and including npts.
  function automatic int count_width(input int npts);
    return $clog2(npts + 1);
  endfunction

endpackage

// File: rtl/cover_event_fifo.sv
// Small synchronous FIFO carrying coverage event indices. Full and empty are
// registered so the producer can decide on enqueue from start-of-cycle state.
module cover_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       next_count;
  logic              do_push;
  logic              do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    next_count = count;
    if (do_push && !do_pop) begin
      next_count = count + 1'b1;
    end else if (do_pop && !do_push) begin
      next_count = count - 1'b1;
    end
  end

  // Pointer, occupancy and flag bookkeeping; flush behaves like a reset.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= next_count;
      full  <= (next_count == (AW + 1)'(DEPTH));
      empty <= (next_count == '0);
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: watches a bus, records the first hit of each
// coverage point, and reports every point exactly once through an event FIFO.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int TOGGLE_MODE = 1,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32,
  parameter int DEPTH       = 4
) (
  input  logic                                                      clock,
  input  logic                                                      reset,
  input  logic [WIDTH-1:0]                                          valid,
  input  logic                                                      enable,
  input  logic                                                      clear,
  output logic                                                      ev_valid,
  input  logic                                                      ev_ready,
  output logic [IDX_W-1:0]                                          ev_index,
  output logic [count_width(cover_points(WIDTH, TOGGLE_MODE))-1:0] covered_count,
  output logic                                                      all_covered
);

  localparam int NPTS  = cover_points(WIDTH, TOGGLE_MODE);
  localparam int CNT_W = count_width(NPTS);

  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic [NPTS-1:0]  hit;
  logic [NPTS-1:0]  seen;
  logic [NPTS-1:0]  pending;
  logic [NPTS-1:0]  sel_onehot;
  logic             sel_any;
  logic [IDX_W-1:0] sel_offset;
  logic [IDX_W-1:0] head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             enqueue;
  logic             dequeue;

  // Previous bus value, sampled every cycle so edge detection never goes stale.
  always_ff @(posedge clock) begin
    prev <= valid;
  end

  // prev only becomes trustworthy one cycle after reset or clear lets go.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      prev_ok <= 1'b0;
    end else begin
      prev_ok <= 1'b1;
    end
  end

  if (TOGGLE_MODE == TOGGLE_EDGE) begin : g_edge
    // Rise lands on the even point, fall on the odd point of each bit.
    always_comb begin
      hit = '0;
      for (int i = 0; i < WIDTH; i++) begin
        hit[2*i]   = enable & prev_ok & valid[i] & ~prev[i];
        hit[2*i+1] = enable & prev_ok & ~valid[i] & prev[i];
      end
    end
  end else begin : g_level
    logic unused_prev;
    assign unused_prev = ^{prev, prev_ok};
    assign hit         = valid & {WIDTH{enable}};
  end

  // Lowest-index pending point wins the single enqueue slot each cycle.
  always_comb begin
    sel_any    = 1'b0;
    sel_onehot = '0;
    sel_offset = '0;
    for (int i = NPTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_any        = 1'b1;
        sel_onehot     = '0;
        sel_onehot[i]  = 1'b1;
        sel_offset     = IDX_W'(i);
      end
    end
  end

  assign enqueue = sel_any & ~fifo_full & ~clear;
  assign dequeue = ev_valid & ev_ready & ~clear;

  // First hits set seen and pending; a pending bit drops once its event is queued.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      seen    <= '0;
      pending <= '0;
    end else begin
      seen    <= seen | hit;
      pending <= (pending & ~(sel_onehot & {NPTS{enqueue}})) | (hit & ~seen);
    end
  end

  // Count completed handshakes since the last reset or clear.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      covered_count <= '0;
    end else if (dequeue) begin
      covered_count <= covered_count + 1'b1;
    end
  end

  assign all_covered = (covered_count == CNT_W'(NPTS));
  assign ev_valid    = ~fifo_empty;
  assign ev_index    = fifo_empty ? '0 : head_data;

  cover_event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (IDX_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (enqueue),
    .push_data (IDX_W'(COVER_INDEX) + sel_offset),
    .pop       (dequeue),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
